// File: rtl/seq_run_detector.sv
// Run-of-symbols detector: flags RUN_LEN consecutive valid symbols equal to a
// programmable pattern, with Moore/Mealy output select and a saturating event counter.
module seq_run_detector #(
    parameter  int RUN_LEN = 2,
    parameter  int DATA_W  = 1,
    parameter  int CNT_W   = 8,
    localparam int CW      = $clog2(RUN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] pattern,
    input  logic              mode_mealy,
    input  logic              overlap,
    input  logic              clr_count,
    output logic              out,
    output logic [1:0]        state,
    output logic [CW-1:0]     run_cnt,
    output logic [CNT_W-1:0]  det_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PART = 2'd1,
        S_FULL = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    localparam logic [CW-1:0]    RUN_MAX  = CW'(RUN_LEN);
    localparam logic [CW-1:0]    RUN_LAST = CW'(RUN_LEN - 1);
    localparam logic [CW-1:0]    RUN_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r, state_s;
    logic [CW-1:0]     run_cnt_r, run_cnt_s;
    logic              det_q_r, det_q_s;
    logic [CNT_W-1:0]  det_count_r, det_count_s;
    logic              match_s, det_s;

    // Match and detection terms from the current run count
    always_comb begin
        match_s = in_valid & (in_data == pattern);
        det_s   = match_s & ((run_cnt_r == RUN_LAST) | (overlap & (run_cnt_r == RUN_MAX)));
    end

    // Next run count and the state derived from it
    always_comb begin
        run_cnt_s = run_cnt_r;
        state_s   = state_r;
        if (state_r == S_BAD) begin
            run_cnt_s = '0;
        end else if (!in_valid) begin
            run_cnt_s = run_cnt_r;
        end else if (!match_s) begin
            run_cnt_s = '0;
        end else if (det_s) begin
            run_cnt_s = overlap ? RUN_MAX : '0;
        end else if (run_cnt_r >= RUN_MAX) begin
            // Saturated run left over after overlap was turned off: restart
            run_cnt_s = '0;
        end else begin
            run_cnt_s = run_cnt_r + RUN_ONE;
        end

        if (run_cnt_s == '0) begin
            state_s = S_IDLE;
        end else if (run_cnt_s < RUN_MAX) begin
            state_s = S_PART;
        end else begin
            state_s = S_FULL;
        end
    end

    // Moore flag and detection counter next values
    always_comb begin
        det_q_s     = det_q_r;
        det_count_s = det_count_r;
        if (in_valid) begin
            det_q_s = det_s;
        end else begin
            det_q_s = det_q_r;
        end
        if (clr_count) begin
            det_count_s = '0;
        end else if (det_s && (det_count_r != CNT_MAX)) begin
            det_count_s = det_count_r + CNT_ONE;
        end else begin
            det_count_s = det_count_r;
        end
    end

    // State, run count, Moore flag and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            run_cnt_r   <= '0;
            det_q_r     <= 1'b0;
            det_count_r <= '0;
        end else begin
            state_r     <= state_s;
            run_cnt_r   <= run_cnt_s;
            det_q_r     <= det_q_s;
            det_count_r <= det_count_s;
        end
    end

    assign out       = mode_mealy ? det_s : det_q_r;
    assign state     = state_r;
    assign run_cnt   = run_cnt_r;
    assign det_count = det_count_r;

endmodule

// File: tb/tb_seq_run_detector.sv
// Bench for seq_run_detector: three parameterisations share one stimulus stream
// and are checked against a behavioural run model plus directed scenarios.
module tb_seq_run_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic [3:0] pattern;
    logic       mode_mealy;
    logic       overlap;
    logic       clr_count;

    logic       out_a, out_b, out_c;
    logic [1:0] state_a, state_b, state_c;
    logic [1:0] run_a, run_b;
    logic [0:0] run_c;
    logic [1:0] cnt_a;
    logic [3:0] cnt_b;
    logic [2:0] cnt_c;

    int n_total = 0;
    int n_bad   = 0;

    // Per-instance parameters: a = legacy (RL2,DW1,CNT2), b = RL3,DW4,CNT4, c = RL1,DW4,CNT3
    int    rl[3]   = '{2, 3, 1};
    int    msk[3]  = '{1, 15, 15};
    int    cmax[3] = '{3, 15, 7};
    string nm[3]   = '{"a", "b", "c"};

    int m_run[3];
    bit m_dq[3];
    int m_cnt[3];

    always #5 clk = ~clk;

    seq_run_detector #(.RUN_LEN(2), .DATA_W(1), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data[0:0]),
        .pattern(pattern[0:0]), .mode_mealy(mode_mealy), .overlap(overlap),
        .clr_count(clr_count), .out(out_a), .state(state_a), .run_cnt(run_a),
        .det_count(cnt_a)
    );

    seq_run_detector #(.RUN_LEN(3), .DATA_W(4), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .pattern(pattern), .mode_mealy(mode_mealy), .overlap(overlap),
        .clr_count(clr_count), .out(out_b), .state(state_b), .run_cnt(run_b),
        .det_count(cnt_b)
    );

    seq_run_detector #(.RUN_LEN(1), .DATA_W(4), .CNT_W(3)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .pattern(pattern), .mode_mealy(mode_mealy), .overlap(overlap),
        .clr_count(clr_count), .out(out_c), .state(state_c), .run_cnt(run_c),
        .det_count(cnt_c)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_match(input int i);
        return in_valid && ((int'(in_data) & msk[i]) == (int'(pattern) & msk[i]));
    endfunction

    function automatic bit m_det(input int i);
        return m_match(i) && ((m_run[i] == rl[i] - 1) || (overlap && (m_run[i] == rl[i])));
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0;
            m_dq[i]  = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_update();
        bit d[3];
        bit mt[3];
        for (int i = 0; i < 3; i++) begin
            d[i]  = m_det(i);
            mt[i] = m_match(i);
        end
        for (int i = 0; i < 3; i++) begin
            if (clr_count) m_cnt[i] = 0;
            else if (d[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
            if (in_valid) begin
                m_dq[i] = d[i];
                if (!mt[i]) m_run[i] = 0;
                else if (d[i]) m_run[i] = overlap ? rl[i] : 0;
                else if (m_run[i] == rl[i]) m_run[i] = 0;
                else m_run[i]++;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] o[3], s[3], r[3], c[3];
        int exp_st;
        o[0] = 32'(out_a);   o[1] = 32'(out_b);   o[2] = 32'(out_c);
        s[0] = 32'(state_a); s[1] = 32'(state_b); s[2] = 32'(state_c);
        r[0] = 32'(run_a);   r[1] = 32'(run_b);   r[2] = 32'(run_c);
        c[0] = 32'(cnt_a);   c[1] = 32'(cnt_b);   c[2] = 32'(cnt_c);
        for (int i = 0; i < 3; i++) begin
            exp_st = (m_run[i] == 0) ? 0 : ((m_run[i] < rl[i]) ? 1 : 2);
            chk_val($sformatf("%s_out", nm[i]), o[i], mode_mealy ? int'(m_det(i)) : int'(m_dq[i]));
            chk_val($sformatf("%s_state", nm[i]), s[i], exp_st);
            chk_val($sformatf("%s_run_cnt", nm[i]), r[i], m_run[i]);
            chk_val($sformatf("%s_det_count", nm[i]), c[i], m_cnt[i]);
        end
    endtask

    // Called at posedge+1: apply a symbol, check before the edge, then take the edge
    task automatic step(input logic v, input logic [3:0] d);
        in_valid = v;
        in_data  = d;
        #1;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_zero();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int leg_seq[5] = '{0, 1, 1, 1, 0};
    int leg_exp[5] = '{0, 0, 1, 1, 0};
    int nov_run[6] = '{1, 2, 0, 1, 2, 0};

    initial begin
        in_valid   = 1'b0;
        in_data    = 4'h0;
        pattern    = 4'h1;
        mode_mealy = 1'b0;
        overlap    = 1'b1;
        clr_count  = 1'b0;
        model_zero();
        do_reset();
        chk_val("reset_out_a", 32'(out_a), 0);
        chk_val("reset_cnt_b", 32'(cnt_b), 0);

        // Legacy two-ones behaviour
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 4'(leg_seq[k]));
            chk_val("legacy_out", 32'(out_a), leg_exp[k]);
        end
        chk_val("legacy_cnt", 32'(cnt_a), 2);

        // Non-overlapping runs of three
        do_reset();
        overlap = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 4'h1);
            chk_val("novl_run", 32'(run_b), nov_run[k]);
            chk_val("novl_not_full", 32'(state_b == 2'd2), 0);
        end
        chk_val("novl_cnt", 32'(cnt_b), 2);

        // Mealy output rises before the edge and drops in the mismatch cycle
        do_reset();
        mode_mealy = 1'b1;
        overlap    = 1'b1;
        step(1'b1, 4'h1);
        in_valid = 1'b1;
        in_data  = 4'h1;
        #1;
        chk_val("mealy_pre_edge", 32'(out_a), 1);
        @(posedge clk);
        model_update();
        #1;
        in_data = 4'h0;
        #1;
        chk_val("mealy_drop", 32'(out_a), 0);
        @(posedge clk);
        model_update();
        #1;

        // Wide symbols with an invalid gap inside the run
        do_reset();
        mode_mealy = 1'b0;
        pattern    = 4'hA;
        step(1'b1, 4'hA);
        step(1'b0, 4'h3);
        step(1'b1, 4'hA);
        chk_val("gap_det_a", 32'(out_a), 1);
        chk_val("gap_run_b", 32'(run_b), 2);
        step(1'b1, 4'h5);
        chk_val("gap_break_a", 32'(run_a), 0);
        chk_val("gap_break_b", 32'(run_b), 0);

        // Asynchronous reset in the middle of a run
        pattern = 4'h1;
        do_reset();
        step(1'b1, 4'h1);
        step(1'b1, 4'h1);
        chk_val("pre_rst_run_b", 32'(run_b), 2);
        reset = 1'b1;
        #1;
        chk_val("rst_run_b", 32'(run_b), 0);
        chk_val("rst_cnt_a", 32'(cnt_a), 0);
        chk_val("rst_out_a", 32'(out_a), 0);
        model_zero();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 4'h1);
        step(1'b1, 4'h1);
        chk_val("post_rst_run_b", 32'(run_b), 2);
        chk_val("post_rst_cnt_b", 32'(cnt_b), 0);

        // Counter saturation, then clear coinciding with a detection
        do_reset();
        repeat (6) step(1'b1, 4'h1);
        chk_val("sat_cnt_a", 32'(cnt_a), 3);
        clr_count = 1'b1;
        step(1'b1, 4'h1);
        clr_count = 1'b0;
        chk_val("clr_cnt_a", 32'(cnt_a), 0);

        // Randomised stream with mode, overlap, pattern, clear and reset activity
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 49) == 0) mode_mealy = ~mode_mealy;
            if ($urandom_range(0, 29) == 0) overlap = ~overlap;
            if ($urandom_range(0, 39) == 0) pattern = 4'($urandom);
            clr_count = ($urandom_range(0, 24) == 0);
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 2) != 0) ? pattern : 4'($urandom));
        end
        clr_count = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
